// File: rtl/address_module_pkg.sv
// Shared layout constants for the per-thread operand address translator.
// Holds default geometry, PO entry field layout and the memory-mapped write map.
package address_module_pkg;

  localparam int DEF_ADDR_WIDTH          = 10;
  localparam int DEF_WRITE_ADDR_WIDTH    = 12;
  localparam int DEF_WRITE_WORD_WIDTH    = 36;
  localparam int DEF_OPERAND_COUNT       = 2;
  localparam int DEF_THREAD_COUNT        = 8;
  localparam int DEF_THREAD_COUNT_WIDTH  = 3;
  localparam int DEF_PO_ENTRY_COUNT      = 4;
  localparam int DEF_PO_ADDR_WIDTH       = 2;
  localparam int DEF_PO_INCR_WIDTH       = 4;

  localparam int DEF_SHARED_BASE         = 0;
  localparam int DEF_SHARED_BOUND        = 3;
  localparam int DEF_INDIRECT_ADDR_BASE  = 4;

  localparam int DEF_PO_ADDR_BASE        = 'h400;
  localparam int DEF_ML_ADDR_BASE        = 'h408;
  localparam int DEF_DO_ADDR             = 'h410;
  localparam int DEF_WRITE_RETIME_STAGES = 0;

  // PO entry packs as {sign, incr, offset}, offset in the low bits.
  localparam int PO_OFFSET_LSB  = 0;
  localparam int PO_INCR_LSB    = DEF_ADDR_WIDTH;
  localparam int PO_SIGN_BIT    = DEF_ADDR_WIDTH + DEF_PO_INCR_WIDTH;
  localparam int PO_ENTRY_WIDTH = DEF_ADDR_WIDTH + DEF_PO_INCR_WIDTH + 1;

  typedef struct packed {
    logic                         sign;
    logic [DEF_PO_INCR_WIDTH-1:0] incr;
    logic [DEF_ADDR_WIDTH-1:0]    offset;
  } po_entry_t;

endpackage

// File: rtl/address_po_update.sv
// Post-increment step of one Programmed Offset, wrapping inside a modulo window.
// A zero window length means plain wrap at 2^ADDR_WIDTH.
module address_po_update #(
  parameter int ADDR_WIDTH = 10,
  parameter int INCR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] off,
  input  logic [INCR_WIDTH-1:0] incr,
  input  logic                  sign,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic [ADDR_WIDTH-1:0] result
);

  // One extra bit so the up-sum can be compared against len before folding.
  logic [ADDR_WIDTH:0] off_x;
  logic [ADDR_WIDTH:0] incr_x;
  logic [ADDR_WIDTH:0] len_x;
  logic [ADDR_WIDTH:0] up_sum;
  logic [ADDR_WIDTH:0] down_wrap;
  logic [ADDR_WIDTH:0] down_plain;
  logic                windowed;

  assign off_x    = {1'b0, off};
  assign incr_x   = (ADDR_WIDTH+1)'(incr);
  assign len_x    = {1'b0, len};
  assign windowed = (len != '0);

  always_comb begin
    up_sum     = off_x + incr_x;
    down_wrap  = off_x + len_x - incr_x;
    down_plain = off_x - incr_x;
    result     = '0;
    if (!sign) begin
      if (windowed && (up_sum >= len_x)) result = ADDR_WIDTH'(up_sum - len_x);
      else                               result = ADDR_WIDTH'(up_sum);
    end else begin
      if (windowed && (off_x < incr_x))  result = ADDR_WIDTH'(down_wrap);
      else                               result = ADDR_WIDTH'(down_plain);
    end
  end

endmodule

// File: rtl/address_module_modulo.sv
// Barrel-threaded operand address translation: shared pass-through, default offset,
// or post-incrementing programmed offset with modulo wrap; tables written memory-mapped.
module address_module_modulo
  import address_module_pkg::*;
#(
  parameter int ADDR_WIDTH          = DEF_ADDR_WIDTH,
  parameter int WRITE_ADDR_WIDTH    = DEF_WRITE_ADDR_WIDTH,
  parameter int WRITE_WORD_WIDTH    = DEF_WRITE_WORD_WIDTH,
  parameter int OPERAND_COUNT       = DEF_OPERAND_COUNT,
  parameter int THREAD_COUNT        = DEF_THREAD_COUNT,
  parameter int THREAD_COUNT_WIDTH  = DEF_THREAD_COUNT_WIDTH,
  parameter int PO_ENTRY_COUNT      = DEF_PO_ENTRY_COUNT,
  parameter int PO_ADDR_WIDTH       = DEF_PO_ADDR_WIDTH,
  parameter int PO_INCR_WIDTH       = DEF_PO_INCR_WIDTH,
  parameter int SHARED_BASE         = DEF_SHARED_BASE,
  parameter int SHARED_BOUND        = DEF_SHARED_BOUND,
  parameter int INDIRECT_ADDR_BASE  = DEF_INDIRECT_ADDR_BASE,
  parameter int PO_ADDR_BASE        = DEF_PO_ADDR_BASE,
  parameter int ML_ADDR_BASE        = DEF_ML_ADDR_BASE,
  parameter int DO_ADDR             = DEF_DO_ADDR,
  parameter int WRITE_RETIME_STAGES = DEF_WRITE_RETIME_STAGES
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [OPERAND_COUNT*ADDR_WIDTH-1:0] raw_addr,
  input  logic                                IO_Ready_current,
  input  logic                                Cancel_current,
  input  logic                                IO_Ready_previous,
  input  logic                                Cancel_previous,
  input  logic [WRITE_ADDR_WIDTH-1:0]         write_addr,
  input  logic [WRITE_WORD_WIDTH-1:0]         write_data,
  output logic [OPERAND_COUNT*ADDR_WIDTH-1:0] offset_addr
);

  localparam int ENTRY_WIDTH     = 1 + PO_INCR_WIDTH + ADDR_WIDTH;
  localparam int RAM_INDEX_WIDTH = THREAD_COUNT_WIDTH + PO_ADDR_WIDTH;
  localparam int RAM_DEPTH       = 1 << RAM_INDEX_WIDTH;
  localparam int DO_DEPTH        = 1 << THREAD_COUNT_WIDTH;

  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] THREAD_ONE  = THREAD_COUNT_WIDTH'(1);

  logic [THREAD_COUNT_WIDTH-1:0] thread;
  logic [THREAD_COUNT_WIDTH-1:0] prev_thread;

  logic [ENTRY_WIDTH-1:0] po_ram [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0]  ml_ram [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0]  do_ram [DO_DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      thread <= '0;
    else if (thread == LAST_THREAD) thread <= '0;
    else                            thread <= thread + THREAD_ONE;
  end

  // Writes come from the instruction one stage ahead, i.e. the thread that just left.
  assign prev_thread = (thread == '0) ? LAST_THREAD : thread - THREAD_ONE;

  logic [WRITE_ADDR_WIDTH-1:0] write_addr_d;

  generate
    if (WRITE_RETIME_STAGES == 0) begin : g_no_retime
      assign write_addr_d = write_addr;
    end else begin : g_retime
      logic [WRITE_ADDR_WIDTH-1:0] stage [WRITE_RETIME_STAGES];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < WRITE_RETIME_STAGES; s++) stage[s] <= '0;
        end else begin
          stage[0] <= write_addr;
          for (int s = 1; s < WRITE_RETIME_STAGES; s++) stage[s] <= stage[s-1];
        end
      end
      assign write_addr_d = stage[WRITE_RETIME_STAGES-1];
    end
  endgenerate

  logic                        write_en;
  logic [WRITE_ADDR_WIDTH-1:0] po_rel;
  logic [WRITE_ADDR_WIDTH-1:0] ml_rel;
  logic                        po_hit;
  logic                        ml_hit;
  logic                        do_hit;
  logic [PO_ADDR_WIDTH-1:0]    po_write_entry;
  logic [PO_ADDR_WIDTH-1:0]    ml_write_entry;
  logic                        unused_write_bits;

  assign write_en       = IO_Ready_previous & ~Cancel_previous;
  assign po_rel         = write_addr_d - WRITE_ADDR_WIDTH'(PO_ADDR_BASE);
  assign ml_rel         = write_addr_d - WRITE_ADDR_WIDTH'(ML_ADDR_BASE);
  assign po_hit         = write_en && (po_rel < WRITE_ADDR_WIDTH'(PO_ENTRY_COUNT));
  assign ml_hit         = write_en && (ml_rel < WRITE_ADDR_WIDTH'(PO_ENTRY_COUNT));
  assign do_hit         = write_en && (write_addr_d == WRITE_ADDR_WIDTH'(DO_ADDR));
  assign po_write_entry = po_rel[PO_ADDR_WIDTH-1:0];
  assign ml_write_entry = ml_rel[PO_ADDR_WIDTH-1:0];
  assign unused_write_bits = ^write_data[WRITE_WORD_WIDTH-1:ENTRY_WIDTH];

  logic [ADDR_WIDTH-1:0]      raw        [OPERAND_COUNT];
  logic [PO_ADDR_WIDTH-1:0]   entry      [OPERAND_COUNT];
  logic [ENTRY_WIDTH-1:0]     po_rd      [OPERAND_COUNT];
  logic [ADDR_WIDTH-1:0]      ml_rd      [OPERAND_COUNT];
  logic [ADDR_WIDTH-1:0]      next_off   [OPERAND_COUNT];
  logic [ADDR_WIDTH-1:0]      translated [OPERAND_COUNT];
  logic [OPERAND_COUNT-1:0]   is_shared;
  logic [OPERAND_COUNT-1:0]   is_indirect;
  logic [ADDR_WIDTH-1:0]      do_rd;

  assign do_rd = do_ram[thread];

  generate
    for (genvar i = 0; i < OPERAND_COUNT; i++) begin : g_op
      logic [ADDR_WIDTH-1:0] shared_rel;
      logic [ADDR_WIDTH-1:0] indirect_rel;

      assign raw[i]          = raw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign shared_rel      = raw[i] - ADDR_WIDTH'(SHARED_BASE);
      assign indirect_rel    = raw[i] - ADDR_WIDTH'(INDIRECT_ADDR_BASE);
      assign is_shared[i]    = (shared_rel <= ADDR_WIDTH'(SHARED_BOUND - SHARED_BASE));
      assign is_indirect[i]  = !is_shared[i] && (indirect_rel < ADDR_WIDTH'(PO_ENTRY_COUNT));
      assign entry[i]        = indirect_rel[PO_ADDR_WIDTH-1:0];
      assign po_rd[i]        = po_ram[{thread, entry[i]}];
      assign ml_rd[i]        = ml_ram[{thread, entry[i]}];

      address_po_update #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INCR_WIDTH (PO_INCR_WIDTH)
      ) u_po_update (
        .off    (po_rd[i][ADDR_WIDTH-1:0]),
        .incr   (po_rd[i][ADDR_WIDTH +: PO_INCR_WIDTH]),
        .sign   (po_rd[i][ENTRY_WIDTH-1]),
        .len    (ml_rd[i]),
        .result (next_off[i])
      );

      assign translated[i] = is_shared[i]   ? raw[i] :
                             is_indirect[i] ? raw[i] + po_rd[i][ADDR_WIDTH-1:0] :
                                              raw[i] + do_rd;
    end
  endgenerate

  // An entry touched by several operands advances once: only its lowest operand writes back.
  logic [OPERAND_COUNT-1:0] inc_en;

  always_comb begin
    inc_en = '0;
    for (int i = 0; i < OPERAND_COUNT; i++) begin
      inc_en[i] = is_indirect[i] & IO_Ready_current & ~Cancel_current;
      for (int j = 0; j < i; j++) begin
        if (is_indirect[j] && (entry[j] == entry[i])) inc_en[i] = 1'b0;
      end
    end
  end

  logic [OPERAND_COUNT-1:0]   wb_valid;
  logic [RAM_INDEX_WIDTH-1:0] wb_index [OPERAND_COUNT];
  logic [ENTRY_WIDTH-1:0]     wb_data  [OPERAND_COUNT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wb_valid <= '0;
    else       wb_valid <= inc_en;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < OPERAND_COUNT; i++) begin
      wb_index[i] <= {thread, entry[i]};
      wb_data[i]  <= {po_rd[i][ENTRY_WIDTH-1:ADDR_WIDTH], next_off[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      offset_addr <= '0;
    end else begin
      for (int i = 0; i < OPERAND_COUNT; i++) offset_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= translated[i];
    end
  end

  // The external write is issued last so it overrides a writeback to the same entry.
  always_ff @(posedge clock) begin
    for (int i = 0; i < OPERAND_COUNT; i++) begin
      if (wb_valid[i]) po_ram[wb_index[i]] <= wb_data[i];
    end
    if (po_hit) po_ram[{prev_thread, po_write_entry}] <= write_data[ENTRY_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (ml_hit) ml_ram[{prev_thread, ml_write_entry}] <= write_data[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (do_hit) do_ram[prev_thread] <= write_data[ADDR_WIDTH-1:0];
  end

endmodule
